// File: rtl/scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner:
// FSM state type, all-off output constants and the BCD digit encoding table.
package scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] CTRL_OFF = 4'hF;

  // Active-high {g,f,e,d,c,b,a} patterns; entry n is the glyph for digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Codes 10..15 are not decimal digits and light no segment.
  function automatic logic [6:0] seg_lookup(input logic [3:0] bcd);
    if (bcd < 4'd10) begin
      return SEG_TABLE[bcd];
    end
    return 7'h00;
  endfunction

endpackage

// File: rtl/scan_mux_ctrl_bcd_to_seg.sv
// Combinational BCD + decimal point to active-low {dp,g,f,e,d,c,b,a}.
module bcd_to_seg
  import scan_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  // Look up the glyph, prepend dp, invert for the common-anode drive.
  always_comb begin
    o_seg = ~{i_dp, seg_lookup(i_bcd)};
  end

endmodule

// File: rtl/scan_mux_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Each digit slot is DEAD_CYC cycles of all-off blanking followed by
// DWELL_CYC cycles driving that digit; a frame is four slots, digit 0 first.
// New values are buffered in a one-entry pending register and only copied
// into the displayed register at a frame boundary, so a frame never mixes
// two values.
// Optional build macro SCAN_LZB_EN: leading-zero blanking of digits 3..1.
//
// Handshake: a transfer happens on a rising edge where upd_valid && upd_ready.
// upd_ready is high exactly when the pending buffer is empty; it drops the
// cycle after a transfer and rises again in the first cycle of the frame in
// which the pending value becomes displayed. upd_valid may be held while
// upd_ready is low; nothing is taken until upd_ready is high at an edge.
module scan_mux_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 1000,
  parameter int unsigned DEAD_CYC  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  output logic        upd_ready,
  output logic [7:0]  segment,
  output logic [3:0]  ctrl,
  output logic        frame_start,
  output state_t      o_dbg_state,
  output logic [1:0]  o_dbg_idx
);

  // One counter serves both phases, so it is sized for the longer one.
  localparam int unsigned MAX_CYC = (DWELL_CYC > DEAD_CYC) ? DWELL_CYC : DEAD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_boundary;

  logic [15:0]      r_disp_data;
  logic [3:0]       r_disp_dp;
  logic [15:0]      r_pend_data;
  logic [3:0]       r_pend_dp;
  logic             r_pend_full;
  logic             w_xfer;

  logic [3:0]       w_digit;
  logic             w_dp;
  logic [7:0]       w_seg;
  logic             w_show;

  // FSM state register: slot phase, digit index and phase counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BLANK;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: count out each phase; leaving SHOW of digit 3 is the frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_boundary  = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == DEAD_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 2'd1;
          w_boundary  = (r_idx == 2'd3);
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign upd_ready = ~r_pend_full;
  assign w_xfer    = upd_valid & ~r_pend_full;

  // Pending/displayed buffers. A boundary with a full buffer promotes it;
  // because a full buffer also holds upd_ready low, a value accepted on the
  // boundary edge itself can only land in an empty buffer and waits a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp_data <= 16'h0000;
      r_disp_dp   <= 4'h0;
      r_pend_data <= 16'h0000;
      r_pend_dp   <= 4'h0;
      r_pend_full <= 1'b0;
    end else if (w_boundary && r_pend_full) begin
      r_disp_data <= r_pend_data;
      r_disp_dp   <= r_pend_dp;
      r_pend_full <= 1'b0;
    end else if (w_xfer) begin
      r_pend_data <= upd_data;
      r_pend_dp   <= upd_dp;
      r_pend_full <= 1'b1;
    end
  end

  // Select the nibble and decimal point of the digit currently being scanned.
  always_comb begin
    w_digit = 4'h0;
    case (r_idx)
      2'd0:    w_digit = r_disp_data[3:0];
      2'd1:    w_digit = r_disp_data[7:4];
      2'd2:    w_digit = r_disp_data[11:8];
      default: w_digit = r_disp_data[15:12];
    endcase
    w_dp = r_disp_dp[r_idx];
  end

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_digit),
    .i_dp  (w_dp),
    .o_seg (w_seg)
  );

`ifdef SCAN_LZB_EN
  // Digit n is a leading zero when it and every higher digit are zero.
  logic w_lz3;
  logic w_lz2;
  logic w_lz1;
  logic w_blank;

  assign w_lz3 = (r_disp_data[15:12] == 4'h0);
  assign w_lz2 = w_lz3 && (r_disp_data[11:8] == 4'h0);
  assign w_lz1 = w_lz2 && (r_disp_data[7:4] == 4'h0);

  // Digit 0 always shows so a value of zero still reads "0".
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd1:    w_blank = w_lz1;
      2'd2:    w_blank = w_lz2;
      2'd3:    w_blank = w_lz3;
      default: w_blank = 1'b0;
    endcase
  end

  assign w_show = (r_state == ST_SHOW) && !w_blank;
`else
  assign w_show = (r_state == ST_SHOW);
`endif

  // Drive outputs from state alone, so an asynchronous reset blanks them at once.
  always_comb begin
    segment = SEG_OFF;
    ctrl    = CTRL_OFF;
    if (w_show) begin
      segment = w_seg;
      ctrl    = ~(4'b0001 << r_idx);
    end
  end

  // Gated with reset so the idle reset state (BLANK, digit 0) does not pulse.
  assign frame_start = reset && (r_state == ST_BLANK) && (r_idx == 2'd0) && (r_cnt == '0);

  assign o_dbg_state = r_state;
  assign o_dbg_idx   = r_idx;

endmodule

// File: tb/tb_scan_mux_ctrl.sv
// Bench for scan_mux_ctrl with DWELL_CYC=4, DEAD_CYC=2 (24-cycle frame).
// Honours SCAN_LZB_EN when compiled with it.
module tb_scan_mux_ctrl;
  import scan_pkg::*;

  localparam int DWELL = 4;
  localparam int DEAD  = 2;
  localparam int SLOT  = DWELL + DEAD;
  localparam int FRAME = 4 * SLOT;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = 16'h0;
  logic [3:0]  upd_dp = 4'h0;
  logic        upd_ready;
  logic [7:0]  segment;
  logic [3:0]  ctrl;
  logic        frame_start;
  state_t      dbg_state;
  logic [1:0]  dbg_idx;

  always #5 clk = ~clk;

  scan_mux_ctrl #(.DWELL_CYC(DWELL), .DEAD_CYC(DEAD)) dut (
    .clk         (clk),
    .reset       (reset),
    .upd_valid   (upd_valid),
    .upd_data    (upd_data),
    .upd_dp      (upd_dp),
    .upd_ready   (upd_ready),
    .segment     (segment),
    .ctrl        (ctrl),
    .frame_start (frame_start),
    .o_dbg_state (dbg_state),
    .o_dbg_idx   (dbg_idx)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // Time is tracked as a cycle number since reset release; slot, phase and
  // digit follow from plain division of that number.
  bit          running = 1'b0;
  int          t_cyc = 0;
  logic [15:0] m_disp = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [15:0] m_pend = 16'h0;
  logic [3:0]  m_pend_dp = 4'h0;
  bit          m_full = 1'b0;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic void model_out(input int t, output logic [7:0] seg,
                                    output logic [3:0] ctl, output logic fs);
    int p;
    int slot;
    int ofs;
    logic [3:0] d;
    logic blank;
    p = t % FRAME;
    slot = p / SLOT;
    ofs = p % SLOT;
    fs = (p == 0);
    seg = 8'hFF;
    ctl = 4'hF;
    if (ofs >= DEAD) begin
      d = m_disp[slot*4 +: 4];
      blank = 1'b0;
`ifdef SCAN_LZB_EN
      blank = (slot >= 1) && ((m_disp >> (4 * slot)) == 16'h0);
`endif
      if (!blank) begin
        ctl = ~(4'b0001 << slot);
        seg = ~{m_dp[slot], enc(d)};
      end
    end
  endfunction

  // Model state advance: the last cycle of a frame promotes a pending value;
  // otherwise an offer is taken whenever the model buffer is empty.
  always @(posedge clk) begin
    if (running) begin
      if ((t_cyc % FRAME) == FRAME - 1 && m_full) begin
        m_disp = m_pend;
        m_dp   = m_pend_dp;
        m_full = 1'b0;
      end else if (upd_valid && !m_full) begin
        m_pend    = upd_data;
        m_pend_dp = upd_dp;
        m_full    = 1'b1;
      end
      t_cyc = t_cyc + 1;
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %h expected %h", name, t_cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e_seg;
    logic [3:0] e_ctl;
    logic       e_fs;
    checks++;
    a_ctrl_onehot: assert ($countones(~ctrl) <= 1)
    else begin
      errors++;
      $display("FAIL ctrl_onehot at t=%0d: got %h expected at most one low bit", t_cyc, ctrl);
    end
    if (running) begin
      model_out(t_cyc, e_seg, e_ctl, e_fs);
      exp_q.push_back(e_seg);
      check("cmp_segment", {8'h0, segment}, {8'h0, exp_q.pop_front()});
      check("cmp_ctrl", {12'h0, ctrl}, {12'h0, e_ctl});
      check("cmp_frame_start", {15'h0, frame_start}, {15'h0, e_fs});
      check("cmp_upd_ready", {15'h0, upd_ready}, {15'h0, !m_full});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic goto_t(input int n);
    int guard;
    guard = 0;
    @(negedge clk);
    while (t_cyc != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (t_cyc != n) begin
      errors++;
      $display("FAIL goto_t: got t=%0d expected t=%0d", t_cyc, n);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset   = 1'b1;
    t_cyc   = 0;
    running = 1'b1;
  endtask

  task automatic assert_reset();
    reset     = 1'b0;
    running   = 1'b0;
    m_disp    = 16'h0;
    m_dp      = 4'h0;
    m_full    = 1'b0;
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] dp);
    upd_valid = 1'b1;
    upd_data  = d;
    upd_dp    = dp;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_segment", {8'h0, segment}, 16'h00FF);
    check("rst_ctrl", {12'h0, ctrl}, 16'h000F);
    check("rst_frame_start", {15'h0, frame_start}, 16'h0000);
    check("rst_upd_ready", {15'h0, upd_ready}, 16'h0001);
    release_reset();

    goto_t(0);
    check("t0_frame_start", {15'h0, frame_start}, 16'h0001);
    check("t0_ctrl", {12'h0, ctrl}, 16'h000F);
    goto_t(2);
    check("t2_ctrl", {12'h0, ctrl}, 16'h000E);
    check("t2_segment", {8'h0, segment}, 16'h00C0);
    goto_t(24);
    check("t24_frame_start", {15'h0, frame_start}, 16'h0001);

    // Mid-frame offer, then a second offer while the buffer is full.
    goto_t(30);
    offer(16'h1234, 4'b0010);
    goto_t(31);
    idle();
    check("t31_ready_low", {15'h0, upd_ready}, 16'h0000);
    goto_t(32);
    offer(16'h5678, 4'b1111);
    goto_t(36);
    idle();
    goto_t(48);
    check("t48_frame_start", {15'h0, frame_start}, 16'h0001);
    check("t48_ready_high", {15'h0, upd_ready}, 16'h0001);
    goto_t(50);
    check("t50_digit0", {8'h0, segment}, 16'h0099);
    goto_t(56);
    check("t56_digit1_dp", {8'h0, segment}, 16'h0030);
    goto_t(62);
    check("t62_digit2", {8'h0, segment}, 16'h00A4);
    goto_t(68);
    check("t68_digit3", {8'h0, segment}, 16'h00F9);

    // Offer landing exactly on the frame-boundary edge is deferred one frame.
    goto_t(71);
    offer(16'h9876, 4'b0000);
    goto_t(72);
    idle();
    check("t72_ready_low", {15'h0, upd_ready}, 16'h0000);
    goto_t(74);
    check("t74_old_digit0", {8'h0, segment}, 16'h0099);
    goto_t(98);
    check("t98_new_digit0", {8'h0, segment}, 16'h0082);

    // Leading zeros, plus an offer held across a boundary with a full buffer.
    goto_t(100);
    offer(16'h0070, 4'b1000);
    goto_t(101);
    idle();
    goto_t(119);
    offer(16'h4321, 4'b0000);
    goto_t(120);
    check("t120_ready_high", {15'h0, upd_ready}, 16'h0001);
    goto_t(121);
    idle();
    check("t121_ready_low", {15'h0, upd_ready}, 16'h0000);
    goto_t(122);
    check("t122_ctrl", {12'h0, ctrl}, 16'h000E);
    check("t122_segment", {8'h0, segment}, 16'h00C0);
    goto_t(128);
    check("t128_ctrl", {12'h0, ctrl}, 16'h000D);
    check("t128_segment", {8'h0, segment}, 16'h00F8);
    goto_t(134);
`ifdef SCAN_LZB_EN
    check("t134_ctrl", {12'h0, ctrl}, 16'h000F);
    check("t134_segment", {8'h0, segment}, 16'h00FF);
`else
    check("t134_ctrl", {12'h0, ctrl}, 16'h000B);
    check("t134_segment", {8'h0, segment}, 16'h00C0);
`endif
    goto_t(140);
`ifdef SCAN_LZB_EN
    check("t140_ctrl", {12'h0, ctrl}, 16'h000F);
    check("t140_segment", {8'h0, segment}, 16'h00FF);
`else
    check("t140_ctrl", {12'h0, ctrl}, 16'h0007);
    check("t140_segment", {8'h0, segment}, 16'h0040);
`endif
    goto_t(146);
    check("t146_digit0", {8'h0, segment}, 16'h00F9);

    // Reset during digit 2 SHOW with a value pending.
    goto_t(150);
    offer(16'h1111, 4'b0001);
    goto_t(151);
    idle();
    goto_t(159);
    #1;
    assert_reset();
    #1;
    check("mid_rst_segment", {8'h0, segment}, 16'h00FF);
    check("mid_rst_ctrl", {12'h0, ctrl}, 16'h000F);
    check("mid_rst_frame_start", {15'h0, frame_start}, 16'h0000);
    check("mid_rst_ready", {15'h0, upd_ready}, 16'h0001);
    repeat (3) @(posedge clk);
    release_reset();
    goto_t(0);
    check("rel_frame_start", {15'h0, frame_start}, 16'h0001);
    goto_t(2);
    check("rel_ctrl", {12'h0, ctrl}, 16'h000E);
    check("rel_segment", {8'h0, segment}, 16'h00C0);
    goto_t(26);
    check("rel_pending_dropped", {8'h0, segment}, 16'h00C0);
    goto_t(40);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no end of sequence expected end before 100000 ns");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
